op_div: RTL

OP_DIV -- requirements
Module: op_div

---
 rtl/op_div.sv | 125 ++++++++++++
 1 files changed

// File: rtl/op_div.sv
// Sequential unsigned divider: one restoring step per clock, MSB first.
// Divide-by-zero skips the iteration and reports q = all ones, rem = r.
module op_div #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] r,
    input  logic [DATA_WIDTH-1:0] s,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] rem,
    output logic                  dz
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] prem_q, prem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  dz_q, dz_d;

    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   diff;
    logic                  borrow;
    logic [DATA_WIDTH-1:0] prem_step;
    logic [DATA_WIDTH-1:0] quo_step;

    // The shifted remainder is below 2*divisor, so the top bit of the
    // (W+1)-bit difference is exactly the borrow.
    always_comb begin
        rem_shift = {prem_q, dvd_q[DATA_WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        borrow    = diff[DATA_WIDTH];
        prem_step = borrow ? rem_shift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        quo_step  = {dvd_q[DATA_WIDTH-2:0], ~borrow};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d  = r;
                    dvs_d  = s;
                    prem_d = '0;
                    cnt_d  = CW'(DATA_WIDTH);
                    if (s == '0) begin
                        state_d = ST_DONE;
                        q_d     = '1;
                        rem_d   = r;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                dvd_d  = quo_step;
                prem_d = prem_step;
                cnt_d  = cnt_q - 1'b1;
                // Results are published on the final step so they are valid during DONE.
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    q_d     = quo_step;
                    rem_d   = prem_step;
                    dz_d    = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign q    = q_q;
    assign rem  = rem_q;
    assign dz   = dz_q;

endmodule
